// File: rtl/bp_fe_queue_rollback_pkg.sv
// Shared constants and helpers for the replayable front-end fetch queue.
package bp_fe_queue_rollback_pkg;

   // Default queue depth used by the front-end top when instantiating the queue.
   localparam int bp_fe_queue_els_gp = 8;

   // True when n is a nonzero power of two; pointer wrap arithmetic relies on it.
   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/bp_fe_queue_rollback_if.sv
// Handshake bundle between the PC generator / back-end and the fetch queue.
interface bp_fe_queue_rollback_if #(
   parameter int width_p = 128,
   parameter int els_p   = 8
);
   localparam int count_width_lp = $clog2(els_p + 1);

   logic [width_p-1:0]        data_i;
   logic                      v_i;
   logic                      ready_o;
   logic [width_p-1:0]        data_o;
   logic                      v_o;
   logic                      yumi_i;
   logic                      commit_v_i;
   logic                      roll_v_i;
   logic                      clr_v_i;
   logic [count_width_lp-1:0] count_o;

   // The queue side: consumes requests, produces status and the head packet.
   modport slave (
      input  data_i, v_i, yumi_i, commit_v_i, roll_v_i, clr_v_i,
      output ready_o, data_o, v_o, count_o
   );

   // The client side: front end enqueues, back end dequeues/commits/rolls.
   modport master (
      output data_i, v_i, yumi_i, commit_v_i, roll_v_i, clr_v_i,
      input  ready_o, data_o, v_o, count_o
   );

endinterface

// File: rtl/bp_fe_queue_rollback_mem.sv
// One-write, one-asynchronous-read storage array for fetch packets.
module bsg_mem_1r1w #(
   parameter int width_p       = 128,
   parameter int els_p         = 8,
   parameter int addr_width_lp = $clog2(els_p)
) (
   input  logic                     w_clk_i,
   input  logic                     w_v_i,
   input  logic [addr_width_lp-1:0] w_addr_i,
   input  logic [width_p-1:0]       w_data_i,
   input  logic [addr_width_lp-1:0] r_addr_i,
   output logic [width_p-1:0]       r_data_o
);

   logic [width_p-1:0] mem [els_p];

   // Write port: capture the packet on an accepted enqueue.
   // NOTE: storage has no reset; validity is tracked by the pointers, so contents before a write are never observed.
   always_ff @(posedge w_clk_i) begin
      if (w_v_i) mem[w_addr_i] <= w_data_i;
   end

   assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bp_fe_queue_rollback.sv
// Replayable fetch queue: packets stay resident after dequeue until committed;
// roll rewinds the read pointer to the commit pointer, clear flushes everything.
module bp_fe_queue_rollback
   import bp_fe_queue_rollback_pkg::*;
#(
   parameter int width_p = 128,
   parameter int els_p   = bp_fe_queue_els_gp
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   bp_fe_queue_rollback_if.slave q
);

   localparam int idx_width_lp   = $clog2(els_p);
   localparam int ptr_width_lp   = idx_width_lp + 1;
   localparam int count_width_lp = $clog2(els_p + 1);

   typedef logic [ptr_width_lp-1:0] ptr_t;

   ptr_t wptr_r, rptr_r, cptr_r;
   ptr_t wptr_n, rptr_n, cptr_n;
   ptr_t rptr_after_deq;
   ptr_t occupancy;
   logic full;
   logic enq, deq, commit;

   // Status is derived only from registered pointers (plus reset for ready).
   assign occupancy  = wptr_r - cptr_r;
   assign full       = (occupancy == ptr_t'(els_p));
   assign q.ready_o  = ~full & ~reset_i;
   assign q.v_o      = (rptr_r != wptr_r);
   assign q.count_o  = count_width_lp'(occupancy);

   // Qualified actions; clear overrides all, roll discards a same-cycle dequeue.
   assign enq            = q.v_i & q.ready_o & ~q.clr_v_i;
   assign deq            = q.yumi_i & ~q.roll_v_i & ~q.clr_v_i;
   assign rptr_after_deq = rptr_r + ptr_t'(deq);
   assign commit         = q.commit_v_i & ~q.clr_v_i & (cptr_r != rptr_after_deq);

   // Next-pointer selection: clear > roll > dequeue; enqueue and commit are independent.
   // NOTE: combinational next-state uses blocking '=' with a default first, so no latch is inferred.
   always_comb begin
      wptr_n = wptr_r + ptr_t'(enq);
      cptr_n = cptr_r + ptr_t'(commit);
      rptr_n = rptr_after_deq;
      if (q.roll_v_i) rptr_n = cptr_n;
      if (q.clr_v_i) begin
         wptr_n = '0;
         rptr_n = '0;
         cptr_n = '0;
      end
   end

   // Pointer registers with asynchronous reset.
   // NOTE: state registers use non-blocking '<=' so all pointers update together at the edge.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wptr_r <= '0;
         rptr_r <= '0;
         cptr_r <= '0;
      end else begin
         wptr_r <= wptr_n;
         rptr_r <= rptr_n;
         cptr_r <= cptr_n;
      end
   end

   bsg_mem_1r1w #(
      .width_p (width_p),
      .els_p   (els_p)
   ) mem (
      .w_clk_i  (clk_i),
      .w_v_i    (enq),
      .w_addr_i (wptr_r[idx_width_lp-1:0]),
      .w_data_i (q.data_i),
      .r_addr_i (rptr_r[idx_width_lp-1:0]),
      .r_data_o (q.data_o)
   );

   // Depth must be a power of two of at least 2 for the wrap-bit scheme to hold.
   if (!is_pow2(els_p) || els_p < 2) begin : g_bad_els
      $error("bp_fe_queue_rollback: els_p must be a power of two >= 2");
   end

`ifndef SYNTHESIS
   // Protocol checks on the client handshake.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!(q.yumi_i && !q.v_o))
            else $error("bp_fe_queue_rollback: yumi_i asserted with v_o low");
         assert (!(q.commit_v_i && !q.clr_v_i && (cptr_r == rptr_after_deq)))
            else $error("bp_fe_queue_rollback: commit with nothing dequeued");
      end
   end
`endif

endmodule
